// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM port arbiter: display reads always win, queued pixel writes
// and a full-frame clear sequence fill the cycles the display leaves free.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FB_SIZE    = 307200,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = PTR_W + 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_index,
  output logic              disp_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_index,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_SIZE - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0]    cnt;
  logic [ADDR_W-1:0]   clr_addr;
  logic [DATA_W-1:0]   clr_val;
  logic                full, empty, push, pop, clr_wr;
  logic                done_nxt, latch_clear;

  assign full  = (cnt == LVL_FULL);
  assign empty = (cnt == '0);

  // Writer handshake: a pixel is transferred on every cycle where wr_valid and
  // wr_ready are both high; wr_ready never depends on wr_valid.
  assign wr_ready = !full && (state == IDLE) && !reset;
  assign push     = wr_valid && wr_ready;

  // Free RAM cycles: CLEAR owns them, otherwise the queue head drains.
  assign clr_wr = (state == CLEAR) && !disp_req && !reset;
  assign pop    = (state != CLEAR) && !disp_req && !empty && !reset;

  always_comb begin
    ram_addr  = disp_addr;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (disp_req) begin
      ram_addr = disp_addr;
    end else if (state == CLEAR) begin
      ram_addr  = clr_addr;
      ram_we    = clr_wr;
      ram_wdata = clr_val;
    end else if (!empty) begin
      ram_addr  = fifo_addr[rd_ptr];
      ram_we    = pop;
      ram_wdata = fifo_data[rd_ptr];
    end
  end

  always_comb begin
    state_nxt   = state;
    done_nxt    = 1'b0;
    latch_clear = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          latch_clear = 1'b1;
          // A push in the same cycle lands ahead of the clear, so drain it first.
          state_nxt = (empty && !push) ? CLEAR : FLUSH;
        end
      end
      FLUSH: begin
        if (empty) state_nxt = CLEAR;
      end
      CLEAR: begin
        if (clr_wr && (clr_addr == CLR_LAST)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state      <= IDLE;
      clear_done <= 1'b0;
      disp_valid <= 1'b0;
      clr_addr   <= '0;
      clr_val    <= '0;
    end else begin
      state      <= state_nxt;
      clear_done <= done_nxt;
      disp_valid <= disp_req;
      if (latch_clear) clr_val <= clear_index;
      if (state != CLEAR)
        clr_addr <= '0;
      else if (clr_wr && (clr_addr != CLR_LAST))
        clr_addr <= clr_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + LVL_W'(1);
        2'b01:   cnt <= cnt - LVL_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Queue storage carries no reset; only the pointers define what is live.
  always_ff @(posedge vga_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  assign disp_index = ram_rdata;
  assign clear_busy = (state != IDLE);
  assign fifo_level = cnt;
  assign fsm_state  = state;

endmodule
